// File: rtl/leaf_stream_packetizer_pkg.sv
// Shared constants and types for the leaf stream packetizer family.
package leaf_stream_packetizer_pkg;

    localparam int PACKET_BITS           = 49;
    localparam int PAYLOAD_BITS          = 32;
    localparam int NUM_LEAF_BITS         = 5;
    localparam int NUM_PORT_BITS         = 4;
    localparam int NUM_ADDR_BITS         = 7;
    localparam int NUM_BRAM_ADDR_BITS    = 7;
    localparam int FREESPACE_UPDATE_SIZE = 64;

    // Packet field positions; the valid flag always occupies the MSB.
    localparam int ADDR_LSB  = PAYLOAD_BITS;
    localparam int PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
    localparam int VALID_BIT = LEAF_LSB + NUM_LEAF_BITS;

    // Remote buffer depth, which is also the starting credit.
    localparam int CREDIT_MAX = 1 << NUM_BRAM_ADDR_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/leaf_credit_counter.sv
// Saturating credit counter: one credit consumed per accepted word, a block
// of credits returned per freespace update, clipped at the buffer depth.
module leaf_credit_counter #(
    parameter int COUNT_BITS  = 7,
    parameter int UPDATE_SIZE = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_i,
    input  logic                upd_i,
    output logic [COUNT_BITS:0] count_o
);

    localparam int MAX_COUNT = 1 << COUNT_BITS;

    logic [COUNT_BITS:0]   count_q;
    logic [COUNT_BITS:0]   count_d;
    logic [COUNT_BITS+1:0] sum;

    // Net effect of consume and return in one cycle, then clip at full depth.
    always_comb begin
        sum = {1'b0, count_q};
        if (dec_i && (count_q != '0)) begin
            sum = sum - (COUNT_BITS+2)'(1);
        end
        if (upd_i) begin
            sum = sum + (COUNT_BITS+2)'(UPDATE_SIZE);
        end
        if (sum > (COUNT_BITS+2)'(MAX_COUNT)) begin
            count_d = (COUNT_BITS+1)'(MAX_COUNT);
        end else begin
            count_d = sum[COUNT_BITS:0];
        end
    end

    // Counter register; reset means the remote buffer is fully empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= (COUNT_BITS+1)'(MAX_COUNT);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Packetizer for one output port: wraps user words with destination header
// and wrapping BRAM address, holds one packet for the arbiter, and stalls the
// user when the remote buffer has no credit left.
module leaf_stream_packetizer
    import leaf_stream_packetizer_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    input  logic                          cfg_vld,
    input  logic [NUM_LEAF_BITS-1:0]      cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]      cfg_dest_port,
    input  logic [PAYLOAD_BITS-1:0]       din_leaf_user2interface,
    input  logic                          vld_user2interface,
    output logic                          ack_interface2user,
    output logic [PACKET_BITS-1:0]        dout_pkt,
    output logic                          vld_pkt,
    input  logic                          rdy_pkt,
    input  logic                          freespace_upd,
    output logic [NUM_BRAM_ADDR_BITS:0]   credit_count
);

    pkt_state_t                 state_q;
    pkt_state_t                 state_d;
    logic [NUM_LEAF_BITS-1:0]   leaf_q;
    logic [NUM_PORT_BITS-1:0]   port_q;
    logic [NUM_ADDR_BITS-1:0]   addr_q;
    logic [PACKET_BITS-1:0]     pkt_q;
    logic [PACKET_BITS-1:0]     pkt_d;
    logic                       vld_q;
    logic                       slot_free;
    logic                       accept;

    leaf_credit_counter #(
        .COUNT_BITS  (NUM_BRAM_ADDR_BITS),
        .UPDATE_SIZE (FREESPACE_UPDATE_SIZE)
    ) u_credit (
        .clk     (clk),
        .reset   (reset),
        .dec_i   (accept),
        .upd_i   (freespace_upd),
        .count_o (credit_count)
    );

    // Handshake: the holding slot frees up in the same cycle the arbiter takes it.
    always_comb begin
        slot_free = !vld_q || rdy_pkt;
        accept    = vld_user2interface && (state_q == RUN) && slot_free
                    && (credit_count != '0);
    end

    // Next state: start is one-way, only reset returns to IDLE.
    always_comb begin
        state_d = state_q;
        if ((state_q == IDLE) && ap_start) begin
            state_d = RUN;
        end
    end

    // Assemble the outgoing packet from the live header and payload.
    always_comb begin
        pkt_d                               = '0;
        pkt_d[VALID_BIT]                    = 1'b1;
        pkt_d[LEAF_LSB +: NUM_LEAF_BITS]    = leaf_q;
        pkt_d[PORT_LSB +: NUM_PORT_BITS]    = port_q;
        pkt_d[ADDR_LSB +: NUM_ADDR_BITS]    = addr_q;
        pkt_d[PAYLOAD_BITS-1:0]             = din_leaf_user2interface;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Header capture, holding register and address pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leaf_q <= '0;
            port_q <= '0;
            addr_q <= '0;
            pkt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && cfg_vld) begin
                leaf_q <= cfg_dest_leaf;
                port_q <= cfg_dest_port;
            end
            if (accept) begin
                pkt_q  <= pkt_d;
                vld_q  <= 1'b1;
                addr_q <= addr_q + 1'b1;
            end else if (rdy_pkt) begin
                vld_q  <= 1'b0;
            end
        end
    end

    assign ack_interface2user = accept;
    assign dout_pkt           = pkt_q;
    assign vld_pkt            = vld_q;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Bench for leaf_stream_packetizer: reference model compared every cycle
// plus directed literal expectations.
module tb_leaf_stream_packetizer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ap_start = 1'b0;
    logic        cfg_vld = 1'b0;
    logic [4:0]  cfg_dest_leaf = '0;
    logic [3:0]  cfg_dest_port = '0;
    logic [31:0] din = '0;
    logic        vld_user = 1'b0;
    logic        ack;
    logic [48:0] dout_pkt;
    logic        vld_pkt;
    logic        rdy_pkt = 1'b1;
    logic        freespace_upd = 1'b0;
    logic [7:0]  credit_count;

    int checks = 0;
    int errors = 0;

    // Reference state: start flag, header, next address, credits, held packet.
    bit          mRunning = 0;
    logic [4:0]  mLeaf = '0;
    logic [3:0]  mPort = '0;
    int          mAddr = 0;
    int          mCredit = 128;
    bit          mHeld = 0;
    logic [48:0] mPkt = '0;

    logic [48:0] obs[$];

    leaf_stream_packetizer dut (
        .clk                     (clk),
        .reset                   (reset),
        .ap_start                (ap_start),
        .cfg_vld                 (cfg_vld),
        .cfg_dest_leaf           (cfg_dest_leaf),
        .cfg_dest_port           (cfg_dest_port),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld_user),
        .ack_interface2user      (ack),
        .dout_pkt                (dout_pkt),
        .vld_pkt                 (vld_pkt),
        .rdy_pkt                 (rdy_pkt),
        .freespace_upd           (freespace_upd),
        .credit_count            (credit_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Compare against the model on every falling edge, then advance the model.
    always @(negedge clk) begin
        bit expAck;
        if (reset) begin
            mRunning = 0; mLeaf = '0; mPort = '0; mAddr = 0;
            mCredit = 128; mHeld = 0;
            checkOutput("reset_dout", dout_pkt, 49'd0);
        end
        expAck = vld_user && mRunning && (!mHeld || rdy_pkt) && (mCredit > 0);
        checkOutput("ack", ack, expAck);
        checkOutput("vld_pkt", vld_pkt, mHeld);
        checkOutput("credit", credit_count, mCredit);
        if (mHeld) checkOutput("dout_pkt", dout_pkt, mPkt);
        if (!reset) begin
            if (vld_pkt && rdy_pkt) obs.push_back(dout_pkt);
            if (expAck) begin
                mPkt  = {1'b1, mLeaf, mPort, 7'(mAddr), din};
                mHeld = 1;
                mAddr = (mAddr + 1) % 128;
            end else if (rdy_pkt) begin
                mHeld = 0;
            end
            mCredit = mCredit - (expAck ? 1 : 0) + (freespace_upd ? 64 : 0);
            if (mCredit > 128) mCredit = 128;
            if (!mRunning) begin
                if (cfg_vld) begin
                    mLeaf = cfg_dest_leaf;
                    mPort = cfg_dest_port;
                end
                if (ap_start) mRunning = 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [4:0] leaf, input logic [3:0] port);
        cfg_vld = 1'b1; cfg_dest_leaf = leaf; cfg_dest_port = port; ap_start = 1'b1;
        step(1);
        cfg_vld = 1'b0;
    endtask

    task automatic streamWords(input logic [31:0] base, input int count,
                               input int budget, output int accepted);
        int cycles = 0;
        accepted = 0;
        vld_user = 1'b1;
        din = base;
        while (accepted < count && cycles < budget) begin
            @(negedge clk);
            if (ack) accepted++;
            @(posedge clk);
            #1;
            din = base + 32'(accepted);
            cycles++;
        end
        vld_user = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1; ap_start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        logic [31:0] heldPayload;
        step(2);
        reset = 1'b0;
        step(1);

        // Basic stream of four words to leaf 5 port 3.
        applyStimulus(5'd5, 4'd3);
        obs.delete();
        streamWords(32'hA000_0000, 4, 20, acc);
        step(2);
        checkOutput("t1_accepted", acc, 4);
        checkOutput("t1_obs_count", obs.size(), 4);
        if (obs.size() == 4) begin
            checkOutput("t1_pkt0", obs[0], {1'b1, 5'd5, 4'd3, 7'd0, 32'hA000_0000});
            checkOutput("t1_pkt3", obs[3], {1'b1, 5'd5, 4'd3, 7'd3, 32'hA000_0003});
        end
        checkOutput("t1_credit", credit_count, 124);

        // Update while nearly full saturates at 128.
        freespace_upd = 1'b1; step(1); freespace_upd = 1'b0;
        checkOutput("sat_124", credit_count, 128);
        freespace_upd = 1'b1; step(1); freespace_upd = 1'b0;
        checkOutput("sat_128", credit_count, 128);

        // Credit exhaustion from a fresh start.
        doReset();
        applyStimulus(5'd5, 4'd3);
        streamWords(32'hB000_0000, 130, 140, acc);
        checkOutput("t2_accepted", acc, 128);
        checkOutput("t2_credit_zero", credit_count, 0);
        checkOutput("t2_ack_low", ack, 0);
        step(2);
        checkOutput("t2_obs_count", obs.size(), 128);
        if (obs.size() == 128) checkOutput("t2_last_addr", obs[127][38:32], 127);
        freespace_upd = 1'b1; step(1); freespace_upd = 1'b0;
        checkOutput("t2_credit_64", credit_count, 64);
        streamWords(32'hC000_0000, 1, 5, acc);
        step(1);
        checkOutput("t2_resume_count", obs.size(), 129);
        if (obs.size() == 129) checkOutput("t2_resume_addr", obs[128][38:32], 0);

        // Backpressure: packet held for five cycles, then released.
        rdy_pkt = 1'b0;
        vld_user = 1'b1; din = 32'hD000_0001;
        step(1);
        heldPayload = 32'hD000_0001;
        din = 32'hD000_0002;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t3_hold_vld", vld_pkt, 1);
            checkOutput("t3_hold_data", dout_pkt[31:0], heldPayload);
            checkOutput("t3_hold_ack", ack, 0);
            @(posedge clk);
            #1;
        end
        rdy_pkt = 1'b1;
        @(negedge clk);
        checkOutput("t3_release_ack", ack, 1);
        @(posedge clk);
        #1;
        vld_user = 1'b0;
        step(2);
        if (obs.size() >= 2) begin
            checkOutput("t3_first_out", obs[obs.size()-2][31:0], 32'hD000_0001);
            checkOutput("t3_second_out", obs[obs.size()-1][31:0], 32'hD000_0002);
        end
        checkOutput("t3_credit", credit_count, 61);

        // Simultaneous accept and update at one credit.
        streamWords(32'hE000_0000, 60, 80, acc);
        checkOutput("t4_credit_one", credit_count, 1);
        vld_user = 1'b1; freespace_upd = 1'b1; din = 32'hE100_0000;
        @(negedge clk);
        checkOutput("t4_ack", ack, 1);
        @(posedge clk);
        #1;
        vld_user = 1'b0; freespace_upd = 1'b0;
        checkOutput("t4_credit_64", credit_count, 64);
        step(2);

        // Reset with a pending packet, then header capture only in IDLE.
        rdy_pkt = 1'b0;
        vld_user = 1'b1; din = 32'hF000_0000;
        step(1);
        vld_user = 1'b0;
        checkOutput("t6_pending", vld_pkt, 1);
        #2;
        reset = 1'b1; ap_start = 1'b0;
        #1;
        checkOutput("t6_vld_async", vld_pkt, 0);
        checkOutput("t6_credit_async", credit_count, 128);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy_pkt = 1'b1;
        obs.delete();
        vld_user = 1'b1; din = 32'h1234_5678;
        @(negedge clk);
        checkOutput("t6_idle_ack", ack, 0);
        @(posedge clk);
        #1;
        vld_user = 1'b0;
        applyStimulus(5'd9, 4'd7);
        cfg_vld = 1'b1; cfg_dest_leaf = 5'd1; cfg_dest_port = 4'd1;
        streamWords(32'h5500_0000, 2, 10, acc);
        cfg_vld = 1'b0;
        step(2);
        checkOutput("t6_obs_count", obs.size(), 2);
        if (obs.size() == 2) begin
            checkOutput("t6_pkt0", obs[0], {1'b1, 5'd9, 4'd7, 7'd0, 32'h5500_0000});
            checkOutput("t6_pkt1", obs[1], {1'b1, 5'd9, 4'd7, 7'd1, 32'h5500_0001});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
